pulse_stretcher: RTL

Converts single-cycle strobes into fixed-width output levels, the inverse of our level-to-pulse single pulser. Every input strobe produces exactly one output pulse of WIDTH cycles. Consecutive output pulses are separated by at least GAP low cycles. Strobes that arrive while an output pulse is in progress are counted and replayed in order. The block drives LEDs, buzzers, and slow peripherals from one-cycle events elsewhere in the lab designs.

---
 rtl/pulse_stretcher.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Turns single-cycle event strobes into WIDTH-cycle output pulses separated
// by at least GAP low cycles. Strobes that arrive while a pulse (or its
// recovery gap) is in progress are counted in `pending` and replayed in
// order. When the counter is full, further strobes are lost and flagged on
// `drop` for one cycle each.

module pulse_stretcher #(
    parameter int WIDTH = 4,
    parameter int GAP   = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             drop
);

    // The phase counter must hold max(WIDTH,GAP)-1.
    localparam int MAX_LEN = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]    CNT_HIGH  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_GAP   = CW'(GAP - 1);
    localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic [CNT_W-1:0] pending_r;
    logic [CNT_W-1:0] pending_s;
    logic             drop_r;
    logic             drop_s;
    logic             out_r;
    logic             busy_r;
    logic             inc_s;
    logic             dec_s;

    // Phase sequencing: decide the next state/counter and whether this
    // cycle queues an event (inc) or consumes a queued one (dec).
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        inc_s   = 1'b0;
        dec_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A strobe in IDLE starts a pulse directly; nothing is queued.
                if (in) begin
                    state_s = ST_HIGH;
                    cnt_s   = CNT_HIGH;
                end else begin
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_HIGH: begin
                inc_s = in;
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_GAP;
                    cnt_s   = CNT_GAP;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r == CNT_ZERO) begin
                    // Last gap cycle: a queued event or a fresh strobe
                    // restarts HIGH at once. A fresh strobe with a non-empty
                    // queue joins the queue while the oldest one leaves, so
                    // the count is unchanged and nothing can be dropped.
                    if ((pending_r != PEND_ZERO) || in) begin
                        state_s = ST_HIGH;
                        cnt_s   = CNT_HIGH;
                        dec_s   = (pending_r != PEND_ZERO) && !in;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    inc_s = in;
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Pending-event accounting with saturation; a lost event raises drop.
    always_comb begin
        pending_s = pending_r;
        drop_s    = 1'b0;
        if (inc_s) begin
            if (pending_r == PEND_MAX) begin
                drop_s = 1'b1;
            end else begin
                pending_s = pending_r + PEND_ONE;
            end
        end else if (dec_s) begin
            pending_s = pending_r - PEND_ONE;
        end else begin
            pending_s = pending_r;
        end
    end

    // State, counters and flag registers; outputs are registered from the
    // next state so they match the state register and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            pending_r <= PEND_ZERO;
            drop_r    <= 1'b0;
            out_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pending_r <= pending_s;
            drop_r    <= drop_s;
            out_r     <= (state_s == ST_HIGH);
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign out     = out_r;
    assign busy    = busy_r;
    assign pending = pending_r;
    assign drop    = drop_r;

endmodule
